// File: rtl/video_timing_gen_mm_if.sv
// Video timing generator bus: mode request in, raster/sync/window out.
// master = generator side, slave = consumer (TMDS encoder / frame-buffer reader).
interface video_timing_gen_mm_if #(
  parameter int CW = 12
);
  logic          mode_sel;
  logic          mode_act;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          frame_start;
  logic          win;
  logic [7:0]    src_x;
  logic [7:0]    src_y;

  modport master (
    input  mode_sel,
    output mode_act, hsync, vsync, de, x, y,
    output frame_start, win, src_x, src_y
  );

  modport slave (
    output mode_sel,
    input  mode_act, hsync, vsync, de, x, y,
    input  frame_start, win, src_x, src_y
  );
endinterface

// File: rtl/video_timing_gen_mm.sv
// Two-mode raster timing generator with a centred integer-scaled
// source window; mode changes take effect only on frame boundaries.
module video_timing_gen_mm #(
  parameter int SRC_W      = 224,
  parameter int SRC_H      = 144,
  parameter int M0_HACT    = 720,
  parameter int M0_HFP     = 16,
  parameter int M0_HSW     = 62,
  parameter int M0_HBP     = 60,
  parameter int M0_VACT    = 480,
  parameter int M0_VFP     = 9,
  parameter int M0_VSW     = 6,
  parameter int M0_VBP     = 30,
  parameter int M0_SCALE   = 3,
  parameter int M0_SYNCPOL = 0,
  parameter int M1_HACT    = 1280,
  parameter int M1_HFP     = 110,
  parameter int M1_HSW     = 40,
  parameter int M1_HBP     = 220,
  parameter int M1_VACT    = 720,
  parameter int M1_VFP     = 5,
  parameter int M1_VSW     = 5,
  parameter int M1_VBP     = 20,
  parameter int M1_SCALE   = 5,
  parameter int M1_SYNCPOL = 1,
  parameter int CW         = 12
) (
  input logic clk,
  input logic rst_n,
  video_timing_gen_mm_if.master bus
);

  localparam int M0_HTOT = M0_HACT + M0_HFP + M0_HSW + M0_HBP;
  localparam int M0_VTOT = M0_VACT + M0_VFP + M0_VSW + M0_VBP;
  localparam int M1_HTOT = M1_HACT + M1_HFP + M1_HSW + M1_HBP;
  localparam int M1_VTOT = M1_VACT + M1_VFP + M1_VSW + M1_VBP;
  localparam int M0_WW   = SRC_W * M0_SCALE;
  localparam int M0_WH   = SRC_H * M0_SCALE;
  localparam int M1_WW   = SRC_W * M1_SCALE;
  localparam int M1_WH   = SRC_H * M1_SCALE;
  localparam int M0_XOFF = (M0_HACT - M0_WW) / 2;
  localparam int M0_YOFF = (M0_VACT - M0_WH) / 2;
  localparam int M1_XOFF = (M1_HACT - M1_WW) / 2;
  localparam int M1_YOFF = (M1_VACT - M1_WH) / 2;
  localparam int TMAX0   = (M0_HTOT > M0_VTOT) ? M0_HTOT : M0_VTOT;
  localparam int TMAX1   = (M1_HTOT > M1_VTOT) ? M1_HTOT : M1_VTOT;
  localparam int TMAX    = ((TMAX0 > TMAX1) ? TMAX0 : TMAX1) - 1;

  localparam logic       IDLE0   = (M0_SYNCPOL == 0);
  localparam logic [7:0] SX_LAST = 8'(SRC_W - 1);
  localparam logic [7:0] SY_LAST = 8'(SRC_H - 1);

  if ((2 ** CW) <= TMAX) begin : g_cw_chk
    $error("CW too narrow for raster totals");
  end
  if (M0_XOFF < 0 || M0_YOFF < 0 || M1_XOFF < 0 || M1_YOFF < 0) begin : g_win_chk
    $error("scaled window larger than active area");
  end

  logic          ms1, ms2, pend;
  logic          mode_q, mode_nxt;
  logic [CW-1:0] hcnt, vcnt;

  logic [CW-1:0] h_last, v_last, hact, vact;
  logic [CW-1:0] hs_on, hs_off, vs_on, vs_off;
  logic [CW-1:0] xoff, xend, yoff, yend;
  logic [7:0]    scl_last;
  logic          pol;

  always_comb begin
    if (mode_q) begin
      h_last   = CW'(M1_HTOT - 1);
      v_last   = CW'(M1_VTOT - 1);
      hact     = CW'(M1_HACT);
      vact     = CW'(M1_VACT);
      hs_on    = CW'(M1_HACT + M1_HFP);
      hs_off   = CW'(M1_HACT + M1_HFP + M1_HSW);
      vs_on    = CW'(M1_VACT + M1_VFP);
      vs_off   = CW'(M1_VACT + M1_VFP + M1_VSW);
      xoff     = CW'(M1_XOFF);
      xend     = CW'(M1_XOFF + M1_WW);
      yoff     = CW'(M1_YOFF);
      yend     = CW'(M1_YOFF + M1_WH);
      scl_last = 8'(M1_SCALE - 1);
      pol      = (M1_SYNCPOL != 0);
    end else begin
      h_last   = CW'(M0_HTOT - 1);
      v_last   = CW'(M0_VTOT - 1);
      hact     = CW'(M0_HACT);
      vact     = CW'(M0_VACT);
      hs_on    = CW'(M0_HACT + M0_HFP);
      hs_off   = CW'(M0_HACT + M0_HFP + M0_HSW);
      vs_on    = CW'(M0_VACT + M0_VFP);
      vs_off   = CW'(M0_VACT + M0_VFP + M0_VSW);
      xoff     = CW'(M0_XOFF);
      xend     = CW'(M0_XOFF + M0_WW);
      yoff     = CW'(M0_YOFF);
      yend     = CW'(M0_YOFF + M0_WH);
      scl_last = 8'(M0_SCALE - 1);
      pol      = (M0_SYNCPOL != 0);
    end
  end

  logic line_end, frame_end;
  assign line_end  = (hcnt == h_last);
  assign frame_end = line_end && (vcnt == v_last);

  // pend tracks a differing request; a revert clears it before the boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms1  <= 1'b0;
      ms2  <= 1'b0;
      pend <= 1'b0;
    end else begin
      ms1  <= bus.mode_sel;
      ms2  <= ms1;
      pend <= (ms2 != mode_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= 1'b0;
    else        mode_q <= mode_nxt;
  end

  always_comb begin
    mode_nxt = mode_q;
    if (frame_end && pend && (ms2 != mode_q)) mode_nxt = ms2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= (vcnt == v_last) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  logic de_c, hs_c, vs_c, win_c, fs_c;
  assign de_c  = (hcnt < hact) && (vcnt < vact);
  assign hs_c  = (hcnt >= hs_on) && (hcnt < hs_off);
  assign vs_c  = (vcnt >= vs_on) && (vcnt < vs_off);
  assign fs_c  = (hcnt == '0) && (vcnt == '0);
  assign win_c = de_c && (hcnt >= xoff) && (hcnt < xend)
              && (vcnt >= yoff) && (vcnt < yend);

  logic          hsync_q, vsync_q, de_q, fs_q, win_q;
  logic [CW-1:0] x_q, y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= IDLE0;
      vsync_q <= IDLE0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      win_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      hsync_q <= hs_c ? pol : ~pol;
      vsync_q <= vs_c ? pol : ~pol;
      de_q    <= de_c;
      fs_q    <= fs_c;
      win_q   <= win_c;
      x_q     <= de_c ? hcnt : '0;
      y_q     <= de_c ? vcnt : '0;
    end
  end

  logic [7:0] px, py, sx_q, sy_q;

  // src_y steps at the start of each window line, ahead of its first pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px   <= '0;
      py   <= '0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      if (win_c) begin
        if (hcnt == xoff) begin
          sx_q <= '0;
          px   <= '0;
        end else if (px == scl_last) begin
          px <= '0;
          if (sx_q != SX_LAST) sx_q <= sx_q + 1'b1;
        end else begin
          px <= px + 1'b1;
        end
      end
      if (hcnt == '0 && vcnt >= yoff && vcnt < yend) begin
        if (vcnt == yoff) begin
          sy_q <= '0;
          py   <= '0;
        end else if (py == scl_last) begin
          py <= '0;
          if (sy_q != SY_LAST) sy_q <= sy_q + 1'b1;
        end else begin
          py <= py + 1'b1;
        end
      end
    end
  end

  assign bus.mode_act    = mode_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.frame_start = fs_q;
  assign bus.win         = win_q;
  assign bus.src_x       = sx_q;
  assign bus.src_y       = sy_q;

endmodule

// File: tb/tb_video_timing_gen_mm.sv
// Scoreboard bench for video_timing_gen_mm using small raster modes
// and randomised mode requests.
module tb_video_timing_gen_mm;

  localparam int SW = 10;
  localparam int SH = 8;
  localparam int HA[2]  = '{40, 60};
  localparam int HF[2]  = '{3, 4};
  localparam int HS[2]  = '{4, 3};
  localparam int HB[2]  = '{5, 6};
  localparam int VA[2]  = '{30, 40};
  localparam int VF[2]  = '{2, 2};
  localparam int VS[2]  = '{3, 2};
  localparam int VB[2]  = '{4, 3};
  localparam int SC[2]  = '{3, 4};
  localparam int POL[2] = '{0, 1};

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        win;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic        mact;
  } exp_t;

  localparam exp_t RST_E = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: '0,
    y: '0, fs: 1'b0, win: 1'b0, sx: '0, sy: '0, mact: 1'b0};

  logic clk;
  logic rst_n;
  video_timing_gen_mm_if #(.CW(12)) bus ();

  video_timing_gen_mm #(
    .SRC_W(SW), .SRC_H(SH),
    .M0_HACT(HA[0]), .M0_HFP(HF[0]), .M0_HSW(HS[0]), .M0_HBP(HB[0]),
    .M0_VACT(VA[0]), .M0_VFP(VF[0]), .M0_VSW(VS[0]), .M0_VBP(VB[0]),
    .M0_SCALE(SC[0]), .M0_SYNCPOL(POL[0]),
    .M1_HACT(HA[1]), .M1_HFP(HF[1]), .M1_HSW(HS[1]), .M1_HBP(HB[1]),
    .M1_VACT(VA[1]), .M1_VFP(VF[1]), .M1_VSW(VS[1]), .M1_VBP(VB[1]),
    .M1_SCALE(SC[1]), .M1_SYNCPOL(POL[1]),
    .CW(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   mp;
  bit   mm;

  function automatic int ht(bit m);
    return HA[m] + HF[m] + HS[m] + HB[m];
  endfunction

  function automatic int ft(bit m);
    return ht(m) * (VA[m] + VF[m] + VS[m] + VB[m]);
  endfunction

  // Expected outputs for pixel index p of a frame in mode m
  function automatic exp_t exp_px(int p, bit m);
    exp_t e;
    int h, v, xo, yo, ps, vs0;
    h   = p % ht(m);
    v   = p / ht(m);
    xo  = (HA[m] - SW * SC[m]) / 2;
    yo  = (VA[m] - SH * SC[m]) / 2;
    ps  = HA[m] + HF[m];
    vs0 = VA[m] + VF[m];
    e.de   = (h < HA[m]) && (v < VA[m]);
    e.hs   = ((h >= ps && h < ps + HS[m]) == (POL[m] != 0));
    e.vs   = ((v >= vs0 && v < vs0 + VS[m]) == (POL[m] != 0));
    e.x    = e.de ? 12'(h) : 12'd0;
    e.y    = e.de ? 12'(v) : 12'd0;
    e.fs   = (p == 0);
    e.win  = e.de && h >= xo && h < xo + SW * SC[m]
          && v >= yo && v < yo + SH * SC[m];
    e.sx   = e.win ? 8'((h - xo) / SC[m]) : 8'd0;
    e.sy   = e.win ? 8'((v - yo) / SC[m]) : 8'd0;
    e.mact = m;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.hs   = bus.hsync;
    a.vs   = bus.vsync;
    a.de   = bus.de;
    a.x    = bus.x;
    a.y    = bus.y;
    a.fs   = bus.frame_start;
    a.win  = bus.win;
    a.sx   = bus.src_x;
    a.sy   = bus.src_y;
    a.mact = bus.mode_act;
    return a;
  endfunction

  function automatic string fmt(exp_t a);
    return $sformatf("hs%0b vs%0b de%0b x%0d y%0d fs%0b win%0b sx%0d sy%0d m%0b",
      a.hs, a.vs, a.de, a.x, a.y, a.fs, a.win, a.sx, a.sy, a.mact);
  endfunction

  task automatic chk(string nm, exp_t a, exp_t e, bit full);
    bit ok;
    ok = a.hs == e.hs && a.vs == e.vs && a.de == e.de && a.x == e.x
      && a.y == e.y && a.fs == e.fs && a.win == e.win && a.mact == e.mact;
    if (full || e.win) ok = ok && a.sx == e.sx && a.sy == e.sy;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s cyc%0d: got %s want %s", nm, cyc, fmt(a), fmt(e));
    end
  endtask

  task automatic chk_int(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s cyc%0d: got %0d want %0d", nm, cyc, got, want);
    end
  endtask

  // Reference model: pixel index within the frame plus current mode
  initial begin : model
    exp_t pe;
    mp = 0;
    mm = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mp = 0;
        mm = 1'b0;
      end else begin
        pe = exp_px(mp, mm);
        mp++;
        if (mp == ft(mm)) begin
          mp = 0;
          if (bus.mode_sel != mm) mm = bus.mode_sel;
        end
        pe.mact = mm;
        sb.push_back(pe);
      end
    end
  end

  initial begin : monitor
    exp_t a, e;
    bit   have_fs, mact_chk, last_mact, fs_mode;
    int   fs_cyc;
    have_fs = 0;
    mact_chk = 0;
    last_mact = 0;
    fs_mode = 0;
    fs_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      a = sample();
      if (!rst_n) begin
        chk("reset_hold", a, RST_E, 1'b1);
        have_fs = 0;
        mact_chk = 0;
        last_mact = a.mact;
      end else begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("pixel", a, e, 1'b0);
        end
        if (mact_chk) chk_int("mode_act_then_fs", int'(a.fs), 1);
        mact_chk = (a.mact != last_mact);
        last_mact = a.mact;
        if (a.fs) begin
          if (have_fs) chk_int("fs_period", cyc - fs_cyc, ft(fs_mode));
          have_fs = 1;
          fs_cyc = cyc;
          fs_mode = a.mact;
        end
      end
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  // Requests are kept clear of the last cycles of a frame
  task automatic set_mode(bit v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mp < ft(mm) - 12) break;
    end
    #1 bus.mode_sel = v;
  endtask

  task automatic wait_mode(bit v, string nm);
    for (int i = 0; i < 2 * ft(1'b1) + 2 * ft(1'b0); i++) begin
      @(negedge clk);
      if (mm == v) break;
    end
    chk_int(nm, int'(bus.mode_act), int'(v));
  endtask

  initial begin : stim
    bit m0, hit;
    rst_n = 1'b0;
    bus.mode_sel = 1'b0;
    run(4);
    #1 rst_n = 1'b1;
    run(2 * ft(1'b0) + 10);

    set_mode(1'b1);
    wait_mode(1'b1, "switch_to_1");
    run(2 * ft(1'b1) + 10);

    repeat (8) begin
      run($urandom_range(100, 2500));
      set_mode(1'($urandom_range(0, 1)));
    end
    wait_mode(bus.mode_sel, "settle");

    for (int i = 0; i < ft(1'b1) + 10; i++) begin
      @(negedge clk);
      if (mp == 5) break;
    end
    m0 = mm;
    #1 bus.mode_sel = ~m0;
    run(50);
    #1 bus.mode_sel = m0;
    run(ft(m0) + 20);
    chk_int("toggle_keeps_mode", int'(bus.mode_act), int'(m0));

    set_mode(1'b1);
    wait_mode(1'b1, "switch_before_reset");
    hit = 0;
    for (int i = 0; i < 2 * ft(1'b1); i++) begin
      @(posedge clk);
      #2;
      if (mm && mp == 15 * ht(1'b1) + 20) begin
        hit = 1;
        break;
      end
    end
    chk_int("reach_mid_frame", int'(hit), 1);
    rst_n = 1'b0;
    sb.delete();
    #1 chk("async_reset", sample(), RST_E, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_mode(1'b1, "held_sel_after_reset");
    run(ft(1'b1) + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
